// File: rtl/stim_alu_gen.sv
`default_nettype none
// ============================================================================
// Module   : stim_alu_gen
// Purpose  : Stimulus/ALU pair generator. A start pulse launches a run that
//            pushes (instruction, result) pairs from a free-running counter
//            into a small first-word-fall-through FIFO. The result is
//            f(counter) for a selectable ALU op (XOR/ADD/SUB/ROTL). A run
//            ends on reaching 'limit' pairs or on 'stop', then drains the
//            FIFO and reports done.
// Ports    : clk, reset_n (async, active low)
//            start, stop           - run control
//            mode[1:0], operand, limit - run configuration, latched at start
//            out_valid/out_ready   - handshake, out_instr/out_result = head
//            busy, done, count     - status
// Revision : 1.0 - initial release
// ============================================================================
module stim_alu_gen #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] limit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] counter;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] operand_q;
  logic [WIDTH-1:0] limit_q;

  logic [WIDTH-1:0] fifo_instr  [DEPTH];
  logic [WIDTH-1:0] fifo_result [DEPTH];
  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]      wr_ptr, rd_ptr;

  logic             full, empty, push, pop, start_run;
  logic [WIDTH-1:0] alu_val;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = out_valid && out_ready;

  assign start_run = ((state == S_IDLE) || (state == S_DONE)) && start && !stop;

  // ALU on the current counter value with the configuration latched at start.
  // ROTL: duplicate the word, shift, and keep the upper half.
  always_comb begin
    alu_val = '0;
    case (mode_q)
      2'd0:    alu_val = counter ^ operand_q;
      2'd1:    alu_val = counter + operand_q;
      2'd2:    alu_val = counter - operand_q;
      default: alu_val = WIDTH'(({counter, counter} << operand_q[SW-1:0]) >> WIDTH);
    endcase
  end

  // Next state and push decision. Stop takes priority over pushing; the
  // push that reaches a non-zero limit is the last one of the run.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_run) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          state_nxt = S_DRAIN;
        end else if (!full) begin
          push = 1'b1;
          if ((limit_q != '0) && ((count + ONE) == limit_q)) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (empty) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      counter   <= '0;
      count     <= '0;
      mode_q    <= 2'd0;
      operand_q <= '0;
      limit_q   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state <= state_nxt;
      if (start_run) begin
        mode_q    <= mode;
        operand_q <= operand;
        limit_q   <= limit;
        counter   <= '0;
        count     <= '0;
      end
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_ONE;
        counter <= counter + ONE;
        count   <= count + ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only visible while out_valid is set.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr[AW-1:0]]  <= counter;
      fifo_result[wr_ptr[AW-1:0]] <= alu_val;
    end
  end

  assign out_valid  = !empty;
  assign out_instr  = out_valid ? fifo_instr[rd_ptr[AW-1:0]]  : '0;
  assign out_result = out_valid ? fifo_result[rd_ptr[AW-1:0]] : '0;
  assign busy       = (state == S_RUN) || (state == S_DRAIN);
  assign done       = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_stim_alu_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_stim_alu_gen
// Purpose  : Directed self-checking bench for stim_alu_gen (WIDTH=16,
//            DEPTH=4). Inputs change and outputs are sampled 1 time unit
//            after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stim_alu_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, stop, out_ready;
  logic [1:0]  mode;
  logic [15:0] operand, limit;
  logic        out_valid, busy, done;
  logic [15:0] out_instr, out_result, count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stim_alu_gen #(.WIDTH(16), .DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .operand    (operand),
    .limit      (limit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_result (out_result),
    .busy       (busy),
    .done       (done),
    .count      (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    check(tag, done, 1);
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [15:0] op, input logic [15:0] lim);
    mode = m; operand = op; limit = lim; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  logic [15:0] rot_c [6] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};
  logic [15:0] rot_r [6] = '{16'hFFEF, 16'hFFFF, 16'h0000, 16'h0010, 16'h0020, 16'h0030};

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    mode = 2'd0; operand = '0; limit = '0;
    tick(); tick();
    check("rst_valid",  out_valid, 0);
    check("rst_busy",   busy, 0);
    check("rst_done",   done, 0);
    check("rst_count",  count, 0);
    check("rst_instr",  out_instr, 0);
    check("rst_result", out_result, 0);
    reset_n = 1'b1;
    tick();

    // ---------------- XOR, free-flowing, limit 5 ----------------
    out_ready = 1'b1;
    pulse_start(2'd0, 16'h00FF, 16'd5);
    check("xor_busy_after_start", busy, 1);
    check("xor_valid_after_start", out_valid, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("xor_valid", out_valid, 1);
      check("xor_instr", out_instr, i);
      check("xor_result", out_result, 16'h00FF - 16'(i));
    end
    check("xor_count", count, 5);
    tick();
    check("xor_done_early", done, 0);
    check("xor_empty", out_valid, 0);
    tick();
    check("xor_done", done, 1);
    check("xor_busy_off", busy, 0);
    check("xor_count_hold", count, 5);

    // ---------------- ADD, back-pressure ----------------
    out_ready = 1'b0;
    pulse_start(2'd1, 16'd3, 16'd0);
    check("bp_count_cleared", count, 0);
    repeat (10) tick();
    check("bp_count", count, 4);
    check("bp_head_instr", out_instr, 0);
    check("bp_head_result", out_result, 3);
    check("bp_busy", busy, 1);
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("bp_stream_instr", out_instr, k);
      check("bp_stream_result", out_result, k + 3);
    end
    pulse_stop();
    wait_done("bp_done");

    // ---------------- SUB, stop and drain ----------------
    out_ready = 1'b0;
    pulse_start(2'd2, 16'd1, 16'd0);
    check("sd_count_restart", count, 0);
    check("sd_done_cleared", done, 0);
    tick(); tick();
    pulse_stop();
    check("sd_count", count, 2);
    check("sd_busy", busy, 1);
    check("sd_done0", done, 0);
    check("sd_head_instr", out_instr, 0);
    check("sd_head_result", out_result, 16'hFFFF);
    tick();
    check("sd_stalled_count", count, 2);
    out_ready = 1'b1;
    tick();
    check("sd_instr1", out_instr, 1);
    check("sd_result1", out_result, 16'h0000);
    tick();
    check("sd_empty", out_valid, 0);
    check("sd_done_pending", done, 0);
    tick();
    check("sd_done", done, 1);

    // ---------------- start while busy ----------------
    pulse_start(2'd0, 16'd0, 16'd0);
    tick(); tick(); tick();
    check("sb_head", out_instr, 2);
    mode = 2'd1; operand = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    check("sb_instr", out_instr, 3);
    check("sb_result", out_result, 3);
    tick();
    check("sb_instr2", out_instr, 4);
    check("sb_result2", out_result, 4);
    pulse_stop();
    wait_done("sb_done");

    // ---------------- reset mid-DRAIN ----------------
    out_ready = 1'b0;
    pulse_start(2'd0, 16'h1234, 16'd0);
    tick(); tick(); tick();
    pulse_stop();
    check("rd_in_drain", busy, 1);
    reset_n = 1'b0;
    #1;
    check("rd_valid",  out_valid, 0);
    check("rd_busy",   busy, 0);
    check("rd_done",   done, 0);
    check("rd_count",  count, 0);
    check("rd_instr",  out_instr, 0);
    check("rd_result", out_result, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // ---------------- start and stop together in IDLE ----------------
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", busy, 0);
    tick();
    check("ss_busy2", busy, 0);
    check("ss_valid", out_valid, 0);
    check("ss_done", done, 0);

    // ---------------- ROTL across counter wrap ----------------
    out_ready = 1'b1;
    pulse_start(2'd3, 16'd4, 16'd0);
    repeat (65534) tick();
    check("rot_pre", out_instr, 16'hFFFD);
    for (int j = 0; j < 6; j++) begin
      tick();
      check("rot_instr", out_instr, rot_c[j]);
      check("rot_result", out_result, rot_r[j]);
    end
    pulse_stop();
    wait_done("rot_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
